// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the stack sequencer: the state encoding of the
// push/pop sequencer and the default stack pointer value loaded on reset.
// -----------------------------------------------------------------------------
package stack_pkg;

  // Stack pointer value after reset unless the instantiating level overrides it.
  localparam logic [15:0] SP_RESET_DEFAULT = 16'hFFFE;

  // A push writes the high byte first at SP-1, then the low byte at SP-2.
  // A pop reads the low byte at SP, then the high byte at SP+1.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_HI = 3'd1,
    PUSH_LO = 3'd2,
    POP_LO  = 3'd3,
    POP_HI  = 3'd4
  } state_e;

endpackage : stack_pkg

// File: rtl/stack_sp_step.sv
// -----------------------------------------------------------------------------
// stack_sp_step
// Combinational stack pointer step: returns the pointer moved by one byte,
// wrapping modulo 2^16 in both directions.
//   sp_i  : current stack pointer
//   dec_i : 1 = decrement (push direction), 0 = increment (pop direction)
//   sp_o  : stepped stack pointer
// -----------------------------------------------------------------------------
module stack_sp_step (
  input  logic [15:0] sp_i,
  input  logic        dec_i,
  output logic [15:0] sp_o
);

  // 16-bit arithmetic drops the carry/borrow, which gives the wrap for free.
  assign sp_o = dec_i ? (sp_i - 16'd1) : (sp_i + 16'd1);

endmodule : stack_sp_step

// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
// Sequences 16-bit stack pushes and pops onto a byte-wide memory port with a
// handshake (request strobe held until ack). The stack grows downwards.
//   i_Clk, i_Rst_n           : clock, asynchronous active-low reset
//   i_SP_Load, i_SP_Data     : load the stack pointer (idle only)
//   i_Push, i_Push_Data      : start a 16-bit push (idle only)
//   i_Pop                    : start a 16-bit pop (idle only)
//   i_Mem_RData, i_Mem_Ack   : memory read data / access completion
//   o_Mem_Addr, o_Mem_WData  : access address (always SP) / write byte
//   o_Mem_Write, o_Mem_Read  : access request strobes
//   o_SP, o_Pop_Data         : stack pointer / last popped value
//   o_Busy, o_Done           : operation in progress / one-cycle completion
// -----------------------------------------------------------------------------
module stack_sequencer
  import stack_pkg::*;
#(
  parameter logic [15:0] P_SP_RESET = SP_RESET_DEFAULT
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_SP_Load,
  input  logic [15:0] i_SP_Data,
  input  logic        i_Push,
  input  logic [15:0] i_Push_Data,
  input  logic        i_Pop,
  input  logic [7:0]  i_Mem_RData,
  input  logic        i_Mem_Ack,
  output logic [15:0] o_Mem_Addr,
  output logic [7:0]  o_Mem_WData,
  output logic        o_Mem_Write,
  output logic        o_Mem_Read,
  output logic [15:0] o_SP,
  output logic [15:0] o_Pop_Data,
  output logic        o_Busy,
  output logic        o_Done
);

  state_e      state_q;
  logic [15:0] sp_q;
  logic [15:0] sp_d;
  logic [15:0] push_data_q;
  logic [15:0] pop_data_q;
  logic [7:0]  pop_lo_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        read_q;
  logic        busy_q;
  logic        done_q;
  logic        sp_dec;

  // Idle and the push states move SP down; the pop states move it up.
  assign sp_dec = (state_q != POP_LO) && (state_q != POP_HI);

  stack_sp_step u_sp_step (
    .sp_i  (sp_q),
    .dec_i (sp_dec),
    .sp_o  (sp_d)
  );

  // NOTE: every state element, including the data holding registers, uses
  // non-blocking assignments and is cleared by the async reset so an aborted
  // operation leaves nothing stale behind.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      sp_q        <= P_SP_RESET;
      push_data_q <= 16'h0000;
      pop_data_q  <= 16'h0000;
      pop_lo_q    <= 8'h00;
      wdata_q     <= 8'h00;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Priority load > push > pop; the losers are simply dropped.
          if (i_SP_Load) begin
            sp_q <= i_SP_Data;
          end else if (i_Push) begin
            push_data_q <= i_Push_Data;
            sp_q        <= sp_d;
            wdata_q     <= i_Push_Data[15:8];
            write_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= PUSH_HI;
          end else if (i_Pop) begin
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= POP_LO;
          end
        end

        PUSH_HI: begin
          if (i_Mem_Ack) begin
            sp_q    <= sp_d;
            wdata_q <= push_data_q[7:0];
            state_q <= PUSH_LO;
          end
        end

        PUSH_LO: begin
          // SP already points at the low byte, which is the new top of stack.
          if (i_Mem_Ack) begin
            wdata_q <= 8'h00;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end

        POP_LO: begin
          if (i_Mem_Ack) begin
            pop_lo_q <= i_Mem_RData;
            sp_q     <= sp_d;
            state_q  <= POP_HI;
          end
        end

        POP_HI: begin
          if (i_Mem_Ack) begin
            pop_data_q <= {i_Mem_RData, pop_lo_q};
            sp_q       <= sp_d;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: begin
          wdata_q <= 8'h00;
          write_q <= 1'b0;
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Mem_Addr  = sp_q;
  assign o_SP        = sp_q;
  assign o_Mem_WData = wdata_q;
  assign o_Mem_Write = write_q;
  assign o_Mem_Read  = read_q;
  assign o_Pop_Data  = pop_data_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;

endmodule : stack_sequencer
